// File: rtl/sequential_divider.sv
// Multi-cycle signed 32-bit restoring divider: one quotient bit per clock, then sign fix-up.
// Optional macro DIVIDER_ZERO_CHECK_EN short-circuits a zero divisor straight to DONE.
module sequential_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        res_ok,
  output logic        div_by_zero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W:0]     rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic [W-1:0]   quotient_q, quotient_d;
  logic [W-1:0]   remainder_q, remainder_d;
  logic           busy_q, busy_d;
  logic           res_ok_q, res_ok_d;
`ifdef DIVIDER_ZERO_CHECK_EN
  logic           dbz_q, dbz_d;
`endif

  logic [W+1:0]   shifted;
  logic [W+1:0]   trial;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + W'(1)) : x;
  endfunction

  // Next-state, datapath and output computation
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    res_ok_d    = res_ok_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    dbz_d       = dbz_q;
`endif
    // rem_q[W] is always 0 after a restoring step, so the 34-bit trial sign is exact
    shifted = {rem_q, dvd_q[W-1]};
    trial   = shifted - (W+2)'(dvs_q);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvd_d     = mag(opA);
          dvs_d     = mag(opB);
          neg_quo_d = opA[W-1] ^ opB[W-1];
          neg_rem_d = opA[W-1];
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = '0;
          state_d   = S_RUN;
          busy_d    = 1'b1;
          res_ok_d  = 1'b0;
`ifdef DIVIDER_ZERO_CHECK_EN
          dbz_d     = 1'b0;
          if (opB == '0) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            res_ok_d    = 1'b1;
            quotient_d  = '1;
            remainder_d = opA;
            dbz_d       = 1'b1;
          end
`endif
        end
      end
      S_RUN: begin
        dvd_d = {dvd_q[W-2:0], 1'b0};
        if (!trial[W+1]) begin
          rem_d = trial[W:0];
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = shifted[W:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == '1) state_d = S_FIX;
      end
      S_FIX: begin
        quotient_d  = neg_quo_q ? (~quo_q + W'(1)) : quo_q;
        remainder_d = neg_rem_q ? (~rem_q[W-1:0] + W'(1)) : rem_q[W-1:0];
        state_d     = S_DONE;
        busy_d      = 1'b0;
        res_ok_d    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      res_ok_q    <= 1'b0;
`ifdef DIVIDER_ZERO_CHECK_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      res_ok_q    <= res_ok_d;
`ifdef DIVIDER_ZERO_CHECK_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign res_ok    = res_ok_q;
`ifdef DIVIDER_ZERO_CHECK_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider: vector table plus reset / ignored-start / back-to-back sequences.
module tb_sequential_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] opA, opB;
  logic [31:0] quotient, remainder;
  logic        busy, res_ok, div_by_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sequential_divider dut (
    .clk(clk), .reset(reset), .start(start), .opA(opA), .opB(opB),
    .quotient(quotient), .remainder(remainder), .busy(busy),
    .res_ok(res_ok), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
    int          busy_cycles;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present operands and start at a falling edge; return right after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    opA = a; opB = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Edge index (after E0) at which res_ok was first seen, and busy cycles on the way.
  task automatic wait_done(output int n, output int busy_cnt);
    busy_cnt = 0;
    for (n = 0; n < 40; n++) begin
      if (n > 0) @(posedge clk);
      @(negedge clk);
      if (res_ok) break;
      if (busy) busy_cnt++;
    end
    if (n >= 40) begin
      tests++; fails++;
      $display("FAIL timeout: res_ok never rose within 40 cycles");
    end
  endtask

  vec_t vecs[$];
  int   n, bc;

  initial begin
`ifdef DIVIDER_ZERO_CHECK_EN
    vecs.push_back('{32'd5,        32'd0, 32'hFFFFFFFF, 32'd5,        1'b1, 0,  0});
    vecs.push_back('{32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 0,  0});
`else
    vecs.push_back('{32'd5,        32'd0, 32'hFFFFFFFF, 32'd5,        1'b0, 33, 33});
    vecs.push_back('{32'hFFFFFFFB, 32'd0, 32'h00000001, 32'hFFFFFFFB, 1'b0, 33, 33});
`endif
    vecs.push_back('{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33, 33});
    vecs.push_back('{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33, 33});
    vecs.push_back('{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 33, 33});
    vecs.push_back('{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 33, 33});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33, 33});
    vecs.push_back('{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, 33, 33});
    vecs.push_back('{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, 33, 33});
    vecs.push_back('{32'd7,        32'd100,      32'd0,        32'd7,        1'b0, 33, 33});
    vecs.push_back('{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 33, 33});
    vecs.push_back('{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0, 33, 33});

    reset = 1'b1; start = 1'b0; opA = '0; opB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient",  quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_flags", {29'd0, busy, res_ok, div_by_zero}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Table-driven vectors, issued back to back
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(n, bc);
      chk($sformatf("v%0d_quotient", i),  quotient, vecs[i].q);
      chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_dbz", i),       32'(div_by_zero), 32'(vecs[i].dbz));
      chk($sformatf("v%0d_latency", i),   32'(n), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].busy_cycles));
      chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
    end

    // Asynchronous reset mid-operation
    start_op(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_quotient",  quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_flags", {29'd0, busy, res_ok, div_by_zero}, 32'd0);
    @(negedge clk) reset = 1'b0;
    start_op(32'd9, 32'd3);
    wait_done(n, bc);
    chk("after_rst_quotient",  quotient, 32'd3);
    chk("after_rst_remainder", remainder, 32'd0);
    chk("after_rst_latency",   32'(n), 32'd33);

    // Start while busy is ignored
    start_op(32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    opA = 32'd50; opB = 32'd5; start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(n, bc);
    chk("ignored_quotient",  quotient, 32'd14);
    chk("ignored_remainder", remainder, 32'd2);
    chk("ignored_latency",   32'(n), 32'd27);

    // Start held in DONE: accepted on the next edge, res_ok drops
    @(negedge clk);
    opA = 32'd50; opB = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_res_ok_drop", 32'(res_ok), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(n, bc);
    chk("b2b_quotient",  quotient, 32'd10);
    chk("b2b_remainder", remainder, 32'd0);
    chk("b2b_latency",   32'(n), 32'd33);

    // Results held in DONE with start low
    repeat (3) @(negedge clk);
    chk("hold_quotient", quotient, 32'd10);
    chk("hold_res_ok", 32'(res_ok), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
